// File: rtl/timer_display_scan.sv
// Display back end for the count-down timer: snapshots hrs/mins/seconds, converts
// them to BCD, scans a 6-digit active-low 7-segment display and flags expiry.

module bcd_field (
  input  logic       CLK,
  input  logic       rst,
  input  logic [7:0] v,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  // 4'hF encodes a dash for out-of-range values
  always_ff @(posedge CLK) begin
    if (rst) begin
      tens <= '0;
      ones <= '0;
    end else if (v > 8'd99) begin
      tens <= 4'hF;
      ones <= 4'hF;
    end else begin
      tens <= 4'(v / 8'd10);
      ones <= 4'(v % 8'd10);
    end
  end
endmodule

module timer_display_scan #(
  parameter int SCAN_DIV   = 4,
  parameter int BLINK_HALF = 250
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [7:0] seconds,
  input  logic [7:0] mins,
  input  logic [7:0] hrs,
  input  logic       Valid,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp,
  output logic       expired,
  output logic       done
);
  localparam int DW = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, EXPIRED} state_t;

  state_t          state;
  logic [2:0][7:0] snap;       // [0]=seconds, [1]=mins, [2]=hrs
  logic            valid_d;
  logic [2:0][3:0] tens_d, ones_d;
  logic [3:0]      dsel;
  logic [DW-1:0]   div;
  logic [2:0]      idx;
  logic [BW-1:0]   blink_cnt;
  logic            phase;
  logic            scan_step, snap_zero, go_armed, go_exp, wrap, blank;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h3F;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (rst) begin
      snap    <= '0;
      valid_d <= 1'b0;
    end else begin
      valid_d <= Valid;
      if (Valid) snap <= {hrs, mins, seconds};
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_bcd
    bcd_field u_bcd (
      .CLK  (CLK),
      .rst  (rst),
      .v    (snap[g]),
      .tens (tens_d[g]),
      .ones (ones_d[g])
    );
  end

  always_comb begin
    dsel = ones_d[0];
    case (idx)
      3'd1:    dsel = tens_d[0];
      3'd2:    dsel = ones_d[1];
      3'd3:    dsel = tens_d[1];
      3'd4:    dsel = ones_d[2];
      3'd5:    dsel = tens_d[2];
      default: dsel = ones_d[0];
    endcase
  end

  assign scan_step = (div == DW'(SCAN_DIV - 1));

  always_ff @(posedge CLK) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (scan_step) begin
      div <= '0;
      idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // FSM acts one cycle after the snapshot so it sees the captured fields
  assign snap_zero = (snap == '0);
  assign go_armed  = valid_d && !snap_zero;
  assign go_exp    = valid_d && snap_zero && (state == ARMED);
  assign wrap      = (state == EXPIRED) && (blink_cnt == BW'(BLINK_HALF - 1));
  // blank follows the phase being written this edge, so blanking starts on the wrap edge
  assign blank     = (state == EXPIRED) && !go_armed && (phase ^ wrap);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      blink_cnt <= '0;
      phase     <= 1'b0;
      expired   <= 1'b0;
      done      <= 1'b0;
      seg       <= 7'h7F;
      an        <= 6'h3F;
      dp        <= 1'b1;
    end else begin
      done    <= go_exp;
      expired <= go_exp || ((state == EXPIRED) && !go_armed);
      case (state)
        IDLE:    if (go_armed) state <= ARMED;
        ARMED:   if (go_exp) begin
                   state     <= EXPIRED;
                   blink_cnt <= '0;
                   phase     <= 1'b0;
                 end
        EXPIRED: if (go_armed) begin
                   state <= ARMED;
                 end else begin
                   blink_cnt <= wrap ? '0 : blink_cnt + 1'b1;
                   if (wrap) phase <= ~phase;
                 end
        default: state <= IDLE;
      endcase
      seg <= seg_code(dsel);
      an  <= blank ? 6'h3F : ~(6'd1 << idx);
      dp  <= blank || !((idx == 3'd2) || (idx == 3'd4));
    end
  end
endmodule

// File: tb/tb_timer_display_scan.sv
// Randomized scoreboard bench: a cycle-indexed reference model queues the expected
// display/expiry outputs per clock edge and a monitor compares them after each edge.

module tb_timer_display_scan;
  localparam int SD = 4;
  localparam int BH = 250;

  logic       CLK = 1'b0;
  logic       rst;
  logic [7:0] seconds, mins, hrs;
  logic       Valid;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp, expired, done;

  timer_display_scan #(.SCAN_DIV(SD), .BLINK_HALF(BH)) dut (
    .CLK(CLK), .rst(rst), .seconds(seconds), .mins(mins), .hrs(hrs), .Valid(Valid),
    .seg(seg), .an(an), .dp(dp), .expired(expired), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp, expired, done, seg_care;
    int         edge_no;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;

  logic [6:0] codes [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h3F};

  // model: m = edges since reset release, sa/sb = snapshot after edge m-1 / m-2
  int   m = 0, mst = 0, rise = 0, edge_cnt = 0;
  int   sa[3], sb[3];
  logic pv = 1'b0;

  task automatic step(input logic r, input logic v, input int h, input int mi, input int s);
    exp_t e;
    int i, f, d, sel;
    logic zero, blk;
    @(negedge CLK);
    rst = r; Valid = v; hrs = 8'(h); mins = 8'(mi); seconds = 8'(s);
    edge_cnt++;
    e.edge_no = edge_cnt;
    e.done = 1'b0;
    if (r) begin
      m = 0; mst = 0; pv = 1'b0;
      for (int k = 0; k < 3; k++) begin sa[k] = 0; sb[k] = 0; end
      e.seg = 7'h7F; e.an = 6'h3F; e.dp = 1'b1; e.expired = 1'b0; e.seg_care = 1'b1;
    end else begin
      m++;
      if (pv) begin
        zero = (sa[0] == 0) && (sa[1] == 0) && (sa[2] == 0);
        if (!zero) mst = 1;
        else if (mst == 1) begin mst = 2; rise = m; e.done = 1'b1; end
      end
      pv = v;
      e.expired = (mst == 2);
      blk = (mst == 2) && ((((m - rise) / BH) % 2) == 1);
      i = ((m - 1) / SD) % 6;
      f = sb[i / 2];
      sel = (f >= 100) ? 10 : ((i % 2) ? f / 10 : f % 10);
      d = sel;
      e.seg = codes[d];
      e.seg_care = !blk;
      e.an = blk ? 6'h3F : ~(6'd1 << i);
      e.dp = blk ? 1'b1 : !((i == 2) || (i == 4));
      for (int k = 0; k < 3; k++) sb[k] = sa[k];
      if (v) begin sa[0] = s; sa[1] = mi; sa[2] = h; end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        total++;
        if ((e.seg_care && seg !== e.seg) || an !== e.an || dp !== e.dp ||
            expired !== e.expired || done !== e.done) begin
          bad++;
          $display("FAIL outputs@edge%0d: got seg=%h an=%h dp=%b exp=%b done=%b, want seg=%h(care=%b) an=%h dp=%b exp=%b done=%b",
                   e.edge_no, seg, an, dp, expired, done, e.seg, e.seg_care, e.an, e.dp, e.expired, e.done);
        end
      end
    end
  end

  initial begin : stim
    int r, h, mi, s;
    rst = 1'b1; Valid = 1'b0; hrs = '0; mins = '0; seconds = '0;
    repeat (3) step(1'b1, 1'b1, 12, 34, 56);
    idle(6);
    step(1'b0, 1'b1, 23, 59, 7);
    idle(30);
    step(1'b0, 1'b1, 23, 59, 150);
    idle(30);
    // expiry, then reset inside the blanked half-period
    step(1'b0, 1'b1, 0, 0, 1);
    idle(3);
    step(1'b0, 1'b1, 0, 0, 0);
    idle(270);
    step(1'b1, 1'b0, 0, 0, 0);
    idle(8);
    // full blink cycle, then re-arm
    step(1'b0, 1'b1, 0, 0, 1);
    idle(2);
    step(1'b0, 1'b1, 0, 0, 0);
    idle(520);
    step(1'b0, 1'b1, 0, 5, 0);
    idle(30);
    // zero while idle must not expire
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b0, 1'b1, 0, 0, 0);
    idle(12);
    for (int k = 0; k < 2500; k++) begin
      r = $urandom_range(0, 3);
      h  = (r == 0) ? 0 : $urandom_range(0, 129);
      mi = (r == 0) ? 0 : $urandom_range(0, 129);
      s  = (r == 0) ? 0 : $urandom_range(0, 129);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) == 0), h, mi, s);
    end
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
